// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline: widths, ALU op codes and the
// ID/EX control bundle.
package core_pkg;

  localparam int XLEN = 32;

  // 4-bit ALU operation encodings produced by decode
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9,
    ALU_LUI  = 4'hA
  } alu_op_e;

  // Control bits carried from ID into EX
  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic [3:0] alu_op;
  } id_ex_ctrl_t;

  // A bubble is an all-zero control word: nothing writes, nothing branches
  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and branch-after-load hazard detection.
module hazard_detect (
  input  logic       id_valid,
  input  logic       id_flush,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       id_branch,
  input  logic       id_jalr,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       mem_memread,
  input  logic [4:0] mem_rd,
  output logic       hazard_stall
);

  logic ex_hit;
  logic mem_hit;
  logic lu;
  logic bl;

  // A pending load result is needed by a source ID actually reads; x0 never counts
  always_comb begin
    ex_hit  = ex_memread & (ex_rd != 5'd0) &
              ((id_uses_rs1 & (ex_rd == id_rs1)) | (id_uses_rs2 & (ex_rd == id_rs2)));
    mem_hit = mem_memread & (mem_rd != 5'd0) &
              ((id_uses_rs1 & (mem_rd == id_rs1)) | (id_uses_rs2 & (mem_rd == id_rs2)));
    lu = ex_hit;
    // Branches/jalr resolve in ID-adjacent logic, so a load still in MEM also blocks them
    bl = (id_branch | id_jalr) & (ex_hit | mem_hit);
    hazard_stall = id_valid & (lu | bl) & ~id_flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard stall generation, bubble insertion,
// global memory-stall freeze and a saturating hazard-stall counter.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_stall,
  input  logic             id_flush,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             id_alusrc,
  input  logic             id_branch,
  input  logic             id_jal,
  input  logic             id_jalr,
  input  logic [3:0]       id_alu_op,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rd,
  output logic             ex_valid,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_pc,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_alusrc,
  output logic             ex_branch,
  output logic             ex_jal,
  output logic             ex_jalr,
  output logic [3:0]       ex_alu_op,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  id_ex_ctrl_t ex_ctrl;
  id_ex_ctrl_t id_ctrl;
  logic        bubble;

  hazard_detect u_hazard (
    .id_valid     (id_valid),
    .id_flush     (id_flush),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_branch    (id_branch),
    .id_jalr      (id_jalr),
    .ex_memread   (ex_ctrl.memread),
    .ex_rd        (ex_rd),
    .mem_memread  (mem_memread),
    .mem_rd       (mem_rd),
    .hazard_stall (hazard_stall)
  );

  // Pack decode control bits and decide whether this cycle injects a bubble
  always_comb begin
    id_ctrl = '{valid:    id_valid,
                regwrite: id_regwrite,
                memread:  id_memread,
                memwrite: id_memwrite,
                memtoreg: id_memtoreg,
                alusrc:   id_alusrc,
                branch:   id_branch,
                jal:      id_jal,
                jalr:     id_jalr,
                alu_op:   id_alu_op};
    bubble      = hazard_stall | id_flush | ~id_valid;
    pc_write    = ~(hazard_stall | mem_stall);
    if_id_write = ~(hazard_stall | mem_stall);
  end

  // Pipeline register: reset, freeze on mem_stall, bubble or capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_ctrl     <= CTRL_BUBBLE;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
    end else if (!mem_stall) begin
      // Data fields always follow ID; on a bubble their value is irrelevant
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_pc       <= id_pc;
      if (bubble) begin
        ex_ctrl <= CTRL_BUBBLE;
        ex_rs1  <= '0;
        ex_rs2  <= '0;
        ex_rd   <= '0;
      end else begin
        ex_ctrl <= id_ctrl;
        ex_rs1  <= id_rs1;
        ex_rs2  <= id_rs2;
        ex_rd   <= id_rd;
      end
    end
  end

  // Saturating count of cycles lost to hazards; frozen cycles are not counted
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (hazard_stall && !mem_stall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

  always_comb begin
    ex_valid    = ex_ctrl.valid;
    ex_regwrite = ex_ctrl.regwrite;
    ex_memread  = ex_ctrl.memread;
    ex_memwrite = ex_ctrl.memwrite;
    ex_memtoreg = ex_ctrl.memtoreg;
    ex_alusrc   = ex_ctrl.alusrc;
    ex_branch   = ex_ctrl.branch;
    ex_jal      = ex_ctrl.jal;
    ex_jalr     = ex_ctrl.jalr;
    ex_alu_op   = ex_ctrl.alu_op;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage (counter narrowed to 4 bits).
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, mem_stall, id_flush, id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic id_uses_rs1, id_uses_rs2;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
  logic id_branch, id_jal, id_jalr;
  logic [3:0] id_alu_op;
  logic mem_memread;
  logic [4:0] mem_rd;
  logic ex_valid;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
  logic ex_branch, ex_jal, ex_jalr;
  logic [3:0] ex_alu_op;
  logic pc_write, if_id_write, hazard_stall;
  logic [CNT_W-1:0] stall_cnt;

  int nvec = 0;
  int nerr = 0;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .mem_stall(mem_stall), .id_flush(id_flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_branch(id_branch),
    .id_jal(id_jal), .id_jalr(id_jalr), .id_alu_op(id_alu_op),
    .mem_memread(mem_memread), .mem_rd(mem_rd),
    .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
    .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_alu_op(ex_alu_op),
    .pc_write(pc_write), .if_id_write(if_id_write), .hazard_stall(hazard_stall),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 nop, 1 load, 2 alu, 3 branch
  task automatic drive(input int kind, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2);
    id_valid    = (kind != 0);
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    id_memread  = (kind == 1);
    id_memtoreg = (kind == 1);
    id_regwrite = (kind == 1) || (kind == 2);
    id_alusrc   = (kind == 1);
    id_branch   = (kind == 3);
    id_memwrite = 1'b0;
    id_jal      = 1'b0;
    id_jalr     = 1'b0;
    id_alu_op   = (kind == 3) ? 4'h1 : 4'h0;
    id_imm      = 32'h100 + 32'(kind);
    id_pc       = id_pc + 32'd4;
    id_rs1_data = 32'hA000_0000 | 32'(rs1);
    id_rs2_data = 32'hB000_0000 | 32'(rs2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; mem_stall = 1'b0; id_flush = 1'b0; mem_memread = 1'b0; mem_rd = 5'd0;
    id_pc = 32'h0;
    drive(0, 0, 0, 0, 0, 0);

    // Reset with random decode inputs
    for (int i = 0; i < 2; i++) begin
      drive(2, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      id_memread = 1'b1;
      tick();
    end
    chk("rst_valid", ex_valid, 0);
    chk("rst_regwrite", ex_regwrite, 0);
    chk("rst_memread", ex_memread, 0);
    chk("rst_rd", ex_rd, 0);
    chk("rst_cnt", stall_cnt, 0);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_pc_write", pc_write, 1);
    chk("rst_if_id_write", if_id_write, 1);
    rst_n = 1'b1;

    // Load-use: lw x5 then add x6,x5,x1
    drive(1, 5'd2, 5'd0, 5'd5, 1, 0); tick();
    chk("lu_ld_memread", ex_memread, 1);
    chk("lu_ld_rd", ex_rd, 5);
    drive(2, 5'd5, 5'd1, 5'd6, 1, 1); #1;
    chk("lu_hazard", hazard_stall, 1);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_if_id_write", if_id_write, 0);
    tick();
    chk("lu_bub_regwrite", ex_regwrite, 0);
    chk("lu_bub_rd", ex_rd, 0);
    chk("lu_bub_valid", ex_valid, 0);
    chk("lu_cnt", stall_cnt, 1);
    chk("lu_hazard_clr", hazard_stall, 0);
    tick();
    chk("lu_add_rd", ex_rd, 6);
    chk("lu_add_rs1", ex_rs1, 5);
    chk("lu_add_regwrite", ex_regwrite, 1);
    chk("lu_add_imm", ex_imm, 32'h102);
    chk("lu_cnt_hold", stall_cnt, 1);

    // Branch directly after load: two stalls
    do_reset();
    drive(1, 5'd2, 5'd0, 5'd7, 1, 0); tick();
    drive(3, 5'd7, 5'd0, 5'd0, 1, 1); #1;
    chk("bl2_hz1", hazard_stall, 1);
    tick();
    mem_memread = 1'b1; mem_rd = 5'd7; #1;
    chk("bl2_bub_valid", ex_valid, 0);
    chk("bl2_hz2", hazard_stall, 1);
    tick();
    mem_memread = 1'b0; mem_rd = 5'd0; #1;
    chk("bl2_hz3", hazard_stall, 0);
    tick();
    chk("bl2_branch", ex_branch, 1);
    chk("bl2_cnt", stall_cnt, 2);

    // Branch with one independent instruction between: one stall
    do_reset();
    drive(1, 5'd2, 5'd0, 5'd7, 1, 0); tick();
    drive(2, 5'd1, 5'd2, 5'd9, 1, 1); #1;
    chk("bl1_indep", hazard_stall, 0);
    tick();
    mem_memread = 1'b1; mem_rd = 5'd7;
    drive(3, 5'd7, 5'd0, 5'd0, 1, 1); #1;
    chk("bl1_hz", hazard_stall, 1);
    tick();
    mem_memread = 1'b0; mem_rd = 5'd0; #1;
    chk("bl1_hz_clr", hazard_stall, 0);
    tick();
    chk("bl1_branch", ex_branch, 1);
    chk("bl1_cnt", stall_cnt, 1);

    // x0 destination and unused source never stall
    do_reset();
    drive(1, 5'd2, 5'd0, 5'd0, 1, 0); tick();
    drive(2, 5'd0, 5'd0, 5'd1, 1, 1); #1;
    chk("x0_hz", hazard_stall, 0);
    chk("x0_pc_write", pc_write, 1);
    tick();
    drive(1, 5'd2, 5'd0, 5'd5, 1, 0); tick();
    drive(2, 5'd1, 5'd5, 5'd6, 1, 0); #1;
    chk("unused_rs2_hz", hazard_stall, 0);
    tick();
    chk("unused_cnt", stall_cnt, 0);
    chk("unused_rd", ex_rd, 6);

    // Freeze during load-use
    do_reset();
    drive(1, 5'd2, 5'd0, 5'd5, 1, 0); tick();
    drive(2, 5'd5, 5'd1, 5'd6, 1, 1);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_pc_write", pc_write, 0);
      tick();
      chk("frz_rd", ex_rd, 5);
      chk("frz_memread", ex_memread, 1);
      chk("frz_cnt", stall_cnt, 0);
    end
    mem_stall = 1'b0; #1;
    chk("frz_rel_hz", hazard_stall, 1);
    tick();
    chk("frz_bub_valid", ex_valid, 0);
    chk("frz_cnt1", stall_cnt, 1);
    tick();
    chk("frz_add_rd", ex_rd, 6);
    chk("frz_cnt_hold", stall_cnt, 1);

    // Flush together with a hazard: bubble, PC advances, no count
    drive(1, 5'd2, 5'd0, 5'd5, 1, 0); tick();
    drive(2, 5'd5, 5'd1, 5'd6, 1, 1);
    id_flush = 1'b1; #1;
    chk("fl_hz", hazard_stall, 0);
    chk("fl_pc_write", pc_write, 1);
    tick();
    id_flush = 1'b0;
    chk("fl_valid", ex_valid, 0);
    chk("fl_rd", ex_rd, 0);
    chk("fl_cnt", stall_cnt, 1);

    // Saturation: branch held against a load sitting in MEM
    do_reset();
    mem_memread = 1'b1; mem_rd = 5'd5;
    drive(3, 5'd5, 5'd0, 5'd0, 1, 1);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", stall_cnt, 4'hF);
    tick();
    chk("sat_hold", stall_cnt, 4'hF);

    // Reset during a stall discards the stalled instruction
    rst_n = 1'b0; tick();
    chk("rst_mid_valid", ex_valid, 0);
    chk("rst_mid_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    mem_memread = 1'b0; mem_rd = 5'd0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Backstop so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
